// File: rtl/bidir_bus_ctrl.sv
// Sequences tristate pad buffers and active-low strobes for a half-duplex parallel bus.
// The FPGA drives the bus only during write phases; every transaction ends in a released turnaround.
module bidir_bus_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int TURN_CYC   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] io_i,
    output logic             io_t,
    input  logic [WIDTH-1:0] io_o,
    output logic             ext_wr_n,
    output logic             ext_rd_n
);

    localparam int MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_CD  = (HOLD_CYC > TURN_CYC) ? HOLD_CYC : TURN_CYC;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Counters run down to zero, so each state loads its length minus one.
    localparam logic [CNT_W-1:0] C_SETUP  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] C_STROBE = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] C_HOLD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] C_TURN   = CNT_W'(TURN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_SETUP,
        S_W_STROBE,
        S_W_HOLD,
        S_R_STROBE,
        S_TURN
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_rdata;
    logic [WIDTH-1:0]   r_io_i;
    logic               r_io_t;
    logic               r_wr_n;
    logic               r_rd_n;
    logic               w_last;

    assign w_last = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= '0;
            r_io_i  <= '0;
            r_io_t  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_busy <= 1'b1;
                        if (we) begin
                            r_state <= S_W_SETUP;
                            r_cnt   <= C_SETUP;
                            r_io_t  <= 1'b0;
                            r_io_i  <= wdata;
                        end else begin
                            r_state <= S_R_STROBE;
                            r_cnt   <= C_STROBE;
                            r_rd_n  <= 1'b0;
                        end
                    end
                end
                S_W_SETUP: begin
                    if (w_last) begin
                        r_state <= S_W_STROBE;
                        r_cnt   <= C_STROBE;
                        r_wr_n  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_W_STROBE: begin
                    if (w_last) begin
                        r_state <= S_W_HOLD;
                        r_cnt   <= C_HOLD;
                        r_wr_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_W_HOLD: begin
                    if (w_last) begin
                        r_state <= S_TURN;
                        r_cnt   <= C_TURN;
                        r_io_t  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_R_STROBE: begin
                    // Capture on the edge that also releases the read strobe.
                    if (w_last) begin
                        r_state <= S_TURN;
                        r_cnt   <= C_TURN;
                        r_rd_n  <= 1'b1;
                        r_rdata <= io_o;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_TURN: begin
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_io_t  <= 1'b1;
                    r_wr_n  <= 1'b1;
                    r_rd_n  <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign io_i     = r_io_i;
    assign io_t     = r_io_t;
    assign ext_wr_n = r_wr_n;
    assign ext_rd_n = r_rd_n;

    a_no_drive_on_read: assert property (@(posedge clk) disable iff (reset)
        !(!r_io_t && !r_rd_n));
    a_one_strobe: assert property (@(posedge clk) disable iff (reset)
        !(!r_wr_n && !r_rd_n));
    a_wr_needs_drive: assert property (@(posedge clk) disable iff (reset)
        !(!r_wr_n && r_io_t));

endmodule

// File: doc/bidir_bus_ctrl.md
Name: bidir_bus_ctrl

Overview:
Sequences a bank of tristate I/O buffers that connect to an external half-duplex parallel bus with active-low read and write strobes. A single-cycle requester interface, PicoBlaze port style, issues read or write transactions. The block generates the buffer data, tristate enables and strobes with programmable setup, strobe, hold and turnaround timing. It sits between the processor port logic and the pad buffers, and guarantees the FPGA never drives the bus while the external device may be driving it.

Parameters:
WIDTH, 8, data bus width in bits
SETUP_CYC, 1, cycles data is driven before ext_wr_n falls (>=1)
STROBE_CYC, 2, cycles ext_wr_n or ext_rd_n is held low (>=1)
HOLD_CYC, 1, cycles data stays driven after ext_wr_n rises (>=1)
TURN_CYC, 1, bus-released turnaround cycles ending every transaction (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req  input  1  transaction request, sampled only when busy=0
we  input  1  1=write, 0=read; captured with req
wdata  input  WIDTH  write data; captured with req
busy  output  1  transaction in progress
done  output  1  one-cycle completion pulse
rdata  output  WIDTH  last read data; held until next read completes
io_i  output  WIDTH  data to the buffer I inputs
io_t  output  1  buffer T, common to all bits; 1=high-Z
io_o  input  WIDTH  data from the buffer O outputs
ext_wr_n  output  1  external write strobe, active low
ext_rd_n  output  1  external read strobe, active low

Behaviour:
- Reset values: io_t=1, io_i=0, ext_wr_n=1, ext_rd_n=1, busy=0, done=0, rdata=0. State is IDLE and the cycle counter is 0.
- All outputs are registered.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_STROBE, TURN.
- IDLE:
  - If req=1 at a clock edge, capture we and wdata.
  - Go to W_SETUP if we=1, otherwise go to R_STROBE.
  - busy=1 from the next cycle.
- W_SETUP lasts SETUP_CYC cycles: io_t=0, io_i=captured wdata, ext_wr_n=1.
- W_STROBE lasts STROBE_CYC cycles: io_t=0, ext_wr_n=0.
- W_HOLD lasts HOLD_CYC cycles: io_t=0, ext_wr_n=1.
- R_STROBE lasts STROBE_CYC cycles: io_t=1, ext_rd_n=0. rdata is loaded from io_o at the edge ending the last R_STROBE cycle.
- TURN lasts TURN_CYC cycles: io_t=1, both strobes high. Both write and read paths pass through TURN.
- TURN exit: return to IDLE. In that same cycle busy=0 and done=1 for exactly one cycle.
  - A req sampled in that cycle is accepted (back-to-back operation).
- Busy duration per transaction: writes take SETUP_CYC+STROBE_CYC+HOLD_CYC+TURN_CYC cycles; reads take STROBE_CYC+TURN_CYC cycles.
- io_i keeps its last driven value while io_t=1; its value is don't-care then.
- Invariants, checked by assertions:
  - Never io_t=0 while ext_rd_n=0.
  - Never ext_wr_n=0 and ext_rd_n=0 together.
  - ext_wr_n=0 only when io_t=0.
  - At least TURN_CYC cycles of io_t=1 separate any two transactions.
- req while busy=1 is ignored and not queued. we and wdata changes while busy have no effect.
- Counter width is sized for the largest timing parameter. Each state's counter reloads on entry; there is no wrap-around.
- reset asserted in any state: at the next edge all outputs return to their reset values. The bus is released immediately, no done is issued, and a partially captured rdata is discarded (rdata=0).
- reset and req in the same cycle: reset wins and the request is dropped.

Test Plan:
1. Defaults, write 0xA5; req accepted at edge 0, cycles numbered 1.. after it -> io_t=0 and io_i=0xA5 in cycles 1-4; ext_wr_n=0 in cycles 2-3; io_t=1 in cycle 5; done=1 and busy=0 in cycle 6; ext_rd_n=1 throughout.
2. Defaults, read with io_o=0x3C -> ext_rd_n=0 in cycles 1-2; io_t=1 in every cycle; rdata=0x3C from cycle 3; done in cycle 4.
3. Write 0x0F, then read request raised in the done cycle with io_o=0xF0 -> read accepted immediately; no cycle has io_t=0 with ext_rd_n=0; at least one io_t=1 cycle before ext_rd_n falls; rdata=0xF0.
4. Write 0xFF with reset asserted in the first W_STROBE cycle -> next cycle io_t=1, ext_wr_n=1, busy=0, rdata=0; no done pulse ever appears.
5. Write 0x11, then req held with we=1 and wdata=0x22 for the whole transaction -> io_i stays 0x11; 0x22 is accepted only in the done cycle; exactly two write strobes occur.
6. SETUP=3, STROBE=4, HOLD=2, TURN=2 -> a write holds busy for 11 cycles with ext_wr_n low for 4; a read holds busy for 6 cycles with ext_rd_n low for 4.
